// File: rtl/tlc_pkg.sv
// Shared traffic-light encodings and the pedestrian scheduler state type.
package tlc_pkg;

  localparam logic [2:0] NS_GREEN  = 3'b000;
  localparam logic [2:0] NS_YELLOW = 3'b001;
  localparam logic [2:0] EW_GREEN  = 3'b010;
  localparam logic [2:0] EW_YELLOW = 3'b011;
  localparam logic [2:0] PED_GREEN = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PENDING,
    S_SERVICING,
    S_HOLDOFF,
    S_PREEMPT
  } sched_state_t;

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for one raw push-button plus a rising-edge detector.
module btn_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic evt
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      prev <= s2;
    end
  end

  // High for the cycle before the edge at which the press is acted on.
  assign evt = s2 & ~prev;

endmodule

// File: rtl/crossing_request_scheduler.sv
// Pedestrian crossing request scheduler with emergency preempt.
// Optional wait-age urgency indicator enabled by CROSSING_WAIT_TIMEOUT_EN.
module crossing_request_scheduler
  import tlc_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int HOLDOFF_CYCLES  = 20,
  parameter int MAX_WAIT_CYCLES = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] ped_btn,
  input  logic               emerg_req,
  input  logic [2:0]         ctrl_state,
  input  logic               ped_req_ready,
  output logic               ped_req_valid,
  output logic               preempt,
  output logic [NUM_BTN-1:0] wait_lamp,
  output logic               ped_urgent,
  output logic [7:0]         served_cnt
);

  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  if (HOLDOFF_CYCLES < 1 || MAX_WAIT_CYCLES < 1) begin : g_bad_cfg
    $error("HOLDOFF_CYCLES and MAX_WAIT_CYCLES must be at least 1");
  end

  sched_state_t       state;
  logic [NUM_BTN-1:0] evt;
  logic [NUM_BTN-1:0] lamp_set;
  logic [NUM_BTN-1:0] batch;
  logic [HW-1:0]      hold_cnt;
  logic               green_seen;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_sync
    btn_edge_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .btn   (ped_btn[g]),
      .evt   (evt[g])
    );
  end

  // Re-presses of a lit button simply OR into an already-set bit.
  assign lamp_set = wait_lamp | evt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      ped_req_valid <= 1'b0;
      preempt       <= 1'b0;
      wait_lamp     <= '0;
      served_cnt    <= '0;
      batch         <= '0;
      hold_cnt      <= '0;
      green_seen    <= 1'b0;
    end else if (emerg_req) begin
      state         <= S_PREEMPT;
      preempt       <= 1'b1;
      ped_req_valid <= 1'b0;
      wait_lamp     <= lamp_set;
    end else begin
      case (state)
        S_IDLE: begin
          wait_lamp <= lamp_set;
          if (|lamp_set) begin
            state         <= S_PENDING;
            ped_req_valid <= 1'b1;
          end
        end
        S_PENDING: begin
          wait_lamp <= lamp_set;
          if (ped_req_ready) begin
            state         <= S_SERVICING;
            ped_req_valid <= 1'b0;
            batch         <= wait_lamp;
            green_seen    <= 1'b0;
          end
        end
        S_SERVICING: begin
          // Only lamps latched before acceptance are retired; later presses survive.
          if (green_seen && ctrl_state != PED_GREEN) begin
            wait_lamp  <= (wait_lamp & ~batch) | evt;
            served_cnt <= served_cnt + 8'd1;
            hold_cnt   <= '0;
            state      <= S_HOLDOFF;
          end else begin
            wait_lamp <= lamp_set;
            if (ctrl_state == PED_GREEN) begin
              green_seen <= 1'b1;
            end
          end
        end
        S_HOLDOFF: begin
          wait_lamp <= lamp_set;
          if (hold_cnt == HW'(HOLDOFF_CYCLES - 1)) begin
            if (|lamp_set) begin
              state         <= S_PENDING;
              ped_req_valid <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        S_PREEMPT: begin
          wait_lamp <= lamp_set;
          preempt   <= 1'b0;
          hold_cnt  <= '0;
          state     <= S_HOLDOFF;
        end
        default: begin
          state         <= S_IDLE;
          ped_req_valid <= 1'b0;
          preempt       <= 1'b0;
        end
      endcase
    end
  end

`ifdef CROSSING_WAIT_TIMEOUT_EN
  localparam int AW = $clog2(MAX_WAIT_CYCLES + 1);

  logic [AW-1:0] age;

  always_ff @(posedge clk) begin
    if (!reset) begin
      age <= '0;
    end else if (wait_lamp == '0) begin
      age <= '0;
    end else if (age != AW'(MAX_WAIT_CYCLES)) begin
      age <= age + AW'(1);
    end
  end

  assign ped_urgent = (age >= AW'(MAX_WAIT_CYCLES));
`else
  assign ped_urgent = 1'b0;
`endif

endmodule
